// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss, main-memory and cache-fill signals of the block fill controller
interface cache_fill_fsm_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_tag_we;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        busy;
  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
           i_fill_done, d_fill_done, busy
  );
  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
           i_fill_done, d_fill_done, busy
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches the 8-word block of an I- or D-cache miss (D first) and writes it into the cache
module cache_fill_fsm (
  input logic clk,
  input logic rst_n,
  cache_fill_fsm_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic        sel_q, sel_d;
  logic [3:0]  req_q, req_d;
  logic [2:0]  ret_q, ret_d;
  logic        accept, in_fill, fill_hit;
  always_comb begin
    accept   = state_q == IDLE && (bus.d_miss || bus.i_miss);
    in_fill  = state_q == FILL;
    fill_hit = in_fill && bus.mem_data_valid;
    state_d  = accept ? FILL : state_q == DONE ? IDLE : fill_hit && ret_q == 3'd7 ? DONE : state_q;
    base_d   = accept ? ((bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0) : base_q;
    sel_d    = accept ? bus.d_miss : sel_q;
    req_d    = accept ? 4'd0 : in_fill && !req_q[3] ? req_q + 4'd1 : req_q;
    ret_d    = accept ? 3'd0 : fill_hit ? ret_q + 3'd1 : ret_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= 16'd0;
      sel_q   <= 1'b0;
      req_q   <= 4'd0;
      ret_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      ret_q   <= ret_d;
    end
  end
  assign bus.mem_en      = in_fill && !req_q[3];
  assign bus.mem_addr    = bus.mem_en ? base_q + {11'd0, req_q, 1'b0} : 16'd0;
  assign bus.fill_we     = fill_hit;
  assign bus.fill_word   = fill_hit ? ret_q : 3'd0;
  assign bus.fill_data   = fill_hit ? bus.mem_data : 16'd0;
  assign bus.fill_tag_we = fill_hit && ret_q == 3'd7;
  assign bus.fill_sel    = sel_q;
  assign bus.i_fill_done = state_q == DONE && !sel_q;
  assign bus.d_fill_done = state_q == DONE && sel_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: per-cycle vector table against a 4-cycle memory model, plus reset sequences
module tb_cache_fill_fsm;
  logic clk, rst_n;
  cache_fill_fsm_if bus();
  cache_fill_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  typedef struct {
    string nm; int t;
    bit im; logic [15:0] ia; bit dm; logic [15:0] da; bit ij;
    bit en; logic [15:0] addr; bit we; logic [2:0] word; logic [15:0] data;
    bit tag; bit idn; bit ddn; bit busy; bit sel;
  } vec_t;
  vec_t vecs[$];
  int checks, errors;
  bit inj;
  bit [3:0] pv;
  logic [15:0] pa [4];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [15:0] mfn(logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction
  always @(posedge clk) begin
    pv <= {pv[2:0], bus.mem_en};
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
  end
  assign bus.mem_data_valid = pv[3] | inj;
  assign bus.mem_data = pv[3] ? mfn(pa[3]) : 16'hDEAD;
  function automatic vec_t mk(string nm, int t, int ft, logic [15:0] base, bit sel,
                              bit im, logic [15:0] ia, bit dm, logic [15:0] da, bit ij);
    vec_t v;
    v.nm = nm; v.t = t; v.im = im; v.ia = ia; v.dm = dm; v.da = da; v.ij = ij;
    v.en   = ft >= 1 && ft <= 8;
    v.addr = v.en ? base + 16'(2 * (ft - 1)) : 16'h0;
    v.we   = ft >= 5 && ft <= 12;
    v.word = v.we ? 3'(ft - 5) : 3'd0;
    v.data = v.we ? mfn(base + 16'(2 * (ft - 5))) : 16'h0;
    v.tag  = ft == 12;
    v.idn  = ft == 13 && !sel;
    v.ddn  = ft == 13 && sel;
    v.busy = ft >= 1 && ft <= 13;
    v.sel  = sel;
    return v;
  endfunction
  task automatic chk(string nm, int t, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
    end
  endtask
  task automatic apply(vec_t v);
    @(negedge clk);
    bus.i_miss = v.im; bus.i_miss_addr = v.ia;
    bus.d_miss = v.dm; bus.d_miss_addr = v.da;
    inj = v.ij;
    #4;
    chk({v.nm, " mem_en"}, v.t, bus.mem_en, v.en);
    chk({v.nm, " mem_addr"}, v.t, bus.mem_addr, v.addr);
    chk({v.nm, " fill_we"}, v.t, bus.fill_we, v.we);
    chk({v.nm, " fill_word"}, v.t, bus.fill_word, v.word);
    chk({v.nm, " fill_data"}, v.t, bus.fill_data, v.data);
    chk({v.nm, " fill_tag_we"}, v.t, bus.fill_tag_we, v.tag);
    chk({v.nm, " i_fill_done"}, v.t, bus.i_fill_done, v.idn);
    chk({v.nm, " d_fill_done"}, v.t, bus.d_fill_done, v.ddn);
    chk({v.nm, " busy"}, v.t, bus.busy, v.busy);
    if (v.busy) chk({v.nm, " fill_sel"}, v.t, bus.fill_sel, v.sel);
  endtask
  initial begin
    checks = 0; errors = 0; inj = 0;
    rst_n = 0;
    bus.i_miss = 0; bus.i_miss_addr = 0; bus.d_miss = 0; bus.d_miss_addr = 0;
    #2;
    chk("reset busy", 0, bus.busy, 0);
    chk("reset mem_en", 0, bus.mem_en, 0);
    chk("reset mem_addr", 0, bus.mem_addr, 0);
    chk("reset fill_we", 0, bus.fill_we, 0);
    chk("reset fill_sel", 0, bus.fill_sel, 0);
    chk("reset fill_tag_we", 0, bus.fill_tag_we, 0);
    chk("reset i_fill_done", 0, bus.i_fill_done, 0);
    chk("reset d_fill_done", 0, bus.d_fill_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t <= 14; t++)
      vecs.push_back(mk("imiss", t, t, 16'h0120, 0, t <= 13, 16'h0126, 0, 16'h0, t == 0 || t >= 13));
    for (int t = 0; t <= 28; t++)
      if (t < 14) vecs.push_back(mk("both", t, t, 16'h8000, 1, 1, 16'h0040, 1, 16'h8006, 0));
      else vecs.push_back(mk("both", t, t - 14, 16'h0040, 0, t <= 27, 16'h0040, 0, 16'h8006, 0));
    for (int t = 0; t <= 14; t++)
      vecs.push_back(mk("drop", t, t, 16'h3450, 1, 0, 16'h0, t < 3, 16'h3456, 0));
    for (int t = 0; t <= 14; t++)
      vecs.push_back(mk("achg", t, t, 16'h0120, 0, t <= 13, t < 4 ? 16'h0126 : 16'h0200, 0, 16'h0, 0));
    for (int t = 0; t <= 14; t++)
      vecs.push_back(mk("top", t, t, 16'hFFF0, 0, t <= 13, 16'hFFFA, 0, 16'h0, 0));
    foreach (vecs[k]) apply(vecs[k]);
    for (int t = 0; t <= 6; t++)
      apply(mk("rst", t, t, 16'h7770, 1, 0, 16'h0, 1, 16'h7777, 0));
    @(negedge clk);
    rst_n = 0;
    bus.d_miss = 0;
    #1;
    chk("rst busy", 7, bus.busy, 0);
    chk("rst mem_en", 7, bus.mem_en, 0);
    chk("rst fill_we", 7, bus.fill_we, 0);
    chk("rst fill_sel", 7, bus.fill_sel, 0);
    @(negedge clk);
    rst_n = 1;
    #4;
    chk("rst busy", 8, bus.busy, 0);
    chk("rst fill_we", 8, bus.fill_we, 0);
    for (int t = 9; t <= 11; t++)
      apply(mk("rst", t, 14, 16'h7770, 1, 0, 16'h0, 0, 16'h0, 0));
    for (int t = 0; t <= 14; t++)
      apply(mk("rstnew", t, t, 16'h0A00, 0, t <= 13, 16'h0A04, 0, 16'h0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the pipeline's instruction and data caches and the shared multi-cycle main memory. On an I-cache or D-cache miss it fetches the full 8-word block containing the missing address. Requests go out one per cycle; each returned word is written into the requesting cache. After the last word it signals completion, so the stalled IF stage or MEM stage can replay its access.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block; the block is 16 bytes, byte-addressed.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_miss  in  1  I-cache miss, level; held high until i_fill_done.
- i_miss_addr  in  16  byte address of the missing instruction.
- d_miss  in  1  D-cache miss, level; held high until d_fill_done.
- d_miss_addr  in  16  byte address of the missing data word.
- mem_en  out  1  read request to main memory this cycle.
- mem_addr  out  16  byte address of the requested word.
- mem_data_valid  in  1  main memory returns one word this cycle, 4 cycles after its request.
- mem_data  in  16  returned word.
- fill_we  out  1  write fill_data into the selected cache this cycle.
- fill_sel  out  1  target cache: 0 = I-cache, 1 = D-cache.
- fill_word  out  3  word index within the block for this write.
- fill_data  out  16  word to write; equals mem_data.
- fill_tag_we  out  1  write the tag and valid bit of the selected cache line; asserted with the last word.
- i_fill_done  out  1  one-cycle pulse: the I-cache block is complete.
- d_fill_done  out  1  one-cycle pulse: the D-cache block is complete.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, FILL, DONE.
- IDLE, accepting a miss:
  - If d_miss is high, latch base = d_miss_addr & 16'hFFF0 and set fill_sel=1. D-cache misses have priority.
  - Otherwise, if i_miss is high, latch base from i_miss_addr the same way and set fill_sel=0.
  - On acceptance, clear req_cnt and ret_cnt, then go to FILL.
- FILL, requests:
  - While req_cnt < 8: mem_en=1, mem_addr = base + 2*req_cnt, then req_cnt increments.
  - req_cnt saturates at 8; no further requests are issued.
- FILL, returns:
  - On each mem_data_valid: fill_we=1, fill_word=ret_cnt[2:0], fill_data=mem_data, then ret_cnt increments.
  - On the word where ret_cnt==7: also fill_tag_we=1, and next state is DONE.
- DONE: pulse i_fill_done or d_fill_done according to fill_sel, then go to IDLE.
  - New misses are not sampled in DONE. The requester's miss line is stale in that cycle.
- The latched base and fill_sel are frozen from acceptance until IDLE. Changes on the miss address inputs mid-fill are ignored.
- A fill is never aborted. If the miss line drops mid-fill (pipeline flush), the block still completes and the done pulse still fires.
- mem_data_valid in IDLE or DONE is ignored: no write, no counter change.
- If both misses are pending, D is served first. i_miss stays high and is accepted in the IDLE cycle after D's DONE.
- Address arithmetic is 16-bit modulo. A block at 16'hFFF0 requests FFF0..FFFE, with no wrap past FFFE.
- Reset values: state IDLE, all outputs 0, base=0, both counters 0, fill_sel=0.

## Timing
- Miss high in an IDLE cycle at T0.
  - T1..T8: requests for words 0..7.
  - T5..T12: returns, one fill_we per cycle.
  - T12: fill_tag_we.
  - T13: DONE with the done pulse.
  - T14: IDLE.
- Miss-to-done latency is 13 cycles, with 14 cycles from miss to the next acceptance.
- fill_we, fill_word, fill_data and fill_tag_we are combinational from mem_data_valid, qualified by state FILL.
- mem_en, mem_addr, busy and the done pulses depend only on registered state.
- rst_n low at any time forces the reset values immediately, including mid-FILL.
  - Memory returns still in flight after reset are dropped, because the block is in IDLE.

## Test plan
- Single I-miss: i_miss=1, i_miss_addr=16'h0126.
  - Requests 0x0120..0x012E on T1..T8.
  - Eight fill_we with fill_sel=0 and fill_word 0..7 on T5..T12.
  - fill_tag_we at T12, i_fill_done at T13, busy low at T14.
- Simultaneous misses: i_miss addr 0x0040 and d_miss addr 0x8006 in the same cycle.
  - The D block (0x8000..0x800E) fills first with d_fill_done.
  - The I block (0x0040..0x004E) is accepted in the following IDLE cycle.
  - Total 28 cycles.
- Reset mid-fill: assert rst_n=0 at T7 of a D fill.
  - Immediately: busy=0, mem_en=0.
  - Later mem_data_valid pulses produce no fill_we.
  - A new i_miss after reset gets a full, correct fill.
- Miss dropped: deassert d_miss at T3.
  - The fill still completes all 8 words, and d_fill_done pulses at T13.
- Address change mid-fill: change i_miss_addr to 0x0200 at T4.
  - mem_addr continues 0x0128.. and stays within the originally latched block.
- Top block: miss addr 16'hFFFA.
  - Requests FFF0..FFFE in order.
  - fill_word 0..7 in order.
